// File: rtl/go_seq_pkg.sv
// Shared definitions for the go-pulse sequencer: FSM encoding and schedule entry layout.
// An entry is stored as {delay, mask}: delay in the upper TW bits, channel mask in the lower CH bits.
package go_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_PULSE = 2'd2,
        ST_DONE  = 2'd3
    } go_seq_state_e;

    localparam int GO_SEQ_CH = 4;
    localparam int GO_SEQ_TW = 16;

    typedef struct packed {
        logic [GO_SEQ_TW-1:0] delay;
        logic [GO_SEQ_CH-1:0] mask;
    } go_seq_entry_t;

endpackage

// File: rtl/go_seq_table.sv
// Schedule table for the go-pulse sequencer: DEPTH x W registers, synchronous write,
// synchronous clear on rst, combinational read.
module go_seq_table
    import go_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = GO_SEQ_TW + GO_SEQ_CH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/go_pulse_sequencer.sv
// Programmable go-pulse sequencer: runs a table of {delay, mask} entries and drives CH go lines
// with PW-cycle pulses. Define GO_SEQ_LOOP_EN to add the 'loop' input for repeating schedules.
module go_pulse_sequencer
    import go_seq_pkg::*;
#(
    parameter int CH    = GO_SEQ_CH,
    parameter int DEPTH = 8,
    parameter int TW    = GO_SEQ_TW,
    parameter int PW    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
`ifdef GO_SEQ_LOOP_EN
    input  logic                     loop,
`endif
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [TW-1:0]            cfg_delay,
    input  logic [CH-1:0]            cfg_mask,
    input  logic [$clog2(DEPTH):0]   cfg_len,
    output logic [CH-1:0]            go_out,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] cur_idx,
    output logic [1:0]               dbg_state
);

    localparam int          AW       = $clog2(DEPTH);
    localparam int          EW       = TW + CH;
    localparam int          PCW      = (PW > 1) ? $clog2(PW) : 1;
    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    go_seq_state_e   r_state;
    logic [CH-1:0]   r_go;
    logic            r_busy;
    logic            r_done;
    logic [AW-1:0]   r_idx;
    logic [AW:0]     r_len;
    logic [TW-1:0]   r_cnt;
    logic [PCW-1:0]  r_pcnt;

    logic            w_loop;
    logic            w_len_ok;
    logic            w_addr_ok;
    logic            w_start_ok;
    logic            w_tbl_we;
    logic            w_last;
    logic [AW-1:0]   w_rd_addr;
    logic [EW-1:0]   w_rd_data;
    logic [TW-1:0]   w_rd_delay;
    logic [CH-1:0]   w_rd_mask;

`ifdef GO_SEQ_LOOP_EN
    assign w_loop = loop;
`else
    assign w_loop = 1'b0;
`endif

    // start is only honoured in IDLE with a legal length; abort in the same cycle cancels it,
    // and an accepted start drops any table write issued alongside it.
    assign w_len_ok   = (cfg_len != '0) && (cfg_len <= LP_DEPTH);
    assign w_addr_ok  = ({1'b0, cfg_addr} < LP_DEPTH);
    assign w_start_ok = (r_state == ST_IDLE) && start && !abort && w_len_ok;
    assign w_tbl_we   = (r_state == ST_IDLE) && cfg_we && !w_start_ok && w_addr_ok;
    assign w_last     = ({1'b0, r_idx} == (r_len - (AW+1)'(1)));

    // Read port looks ahead: entry 0 when starting or wrapping, entry idx+1 at the end of a pulse.
    always_comb begin
        w_rd_addr = '0;
        case (r_state)
            ST_WAIT:  w_rd_addr = r_idx;
            ST_PULSE: w_rd_addr = w_last ? '0 : r_idx + AW'(1);
            default:  w_rd_addr = '0;
        endcase
    end

    go_seq_table #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_tbl_we),
        .i_waddr (cfg_addr),
        .i_wdata ({cfg_delay, cfg_mask}),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    assign w_rd_delay = w_rd_data[EW-1:CH];
    assign w_rd_mask  = w_rd_data[CH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_go    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_pcnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort && (r_state != ST_IDLE)) begin
                r_state <= ST_IDLE;
                r_go    <= '0;
                r_busy  <= 1'b0;
                r_idx   <= '0;
                r_cnt   <= '0;
                r_pcnt  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start_ok) begin
                            r_len   <= cfg_len;
                            r_idx   <= '0;
                            r_cnt   <= w_rd_delay;
                            r_busy  <= 1'b1;
                            r_state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - TW'(1);
                        end else begin
                            r_go    <= w_rd_mask;
                            r_pcnt  <= PCW'(PW - 1);
                            r_state <= ST_PULSE;
                        end
                    end
                    ST_PULSE: begin
                        if (r_pcnt != '0) begin
                            r_pcnt <= r_pcnt - PCW'(1);
                        end else begin
                            r_go <= '0;
                            if (w_last && w_loop) begin
                                r_done  <= 1'b1;
                                r_idx   <= '0;
                                r_cnt   <= w_rd_delay;
                                r_state <= ST_WAIT;
                            end else if (w_last) begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= ST_DONE;
                            end else begin
                                r_idx   <= r_idx + AW'(1);
                                r_cnt   <= w_rd_delay;
                                r_state <= ST_WAIT;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_idx   <= '0;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign go_out    = r_go;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cur_idx   = r_idx;
    assign dbg_state = r_state;

endmodule
